fmap_sram_reader: RTL
=====================

Name: fmap_sram_reader

Overview:
- Raster-scan read engine on the read port of the feature-map SRAM in the LeNet datapath.
- Takes a rectangular tile descriptor: base address, row stride, column count, row count.
- Drives the SRAM read port, absorbs its 1-cycle registered read latency, and delivers a valid/ready stream with row/frame markers to the downstream conv/pool stage.
- Has full backpressure support and never drops or duplicates a word.

Parameters:
- DATA_WIDTH, 8, SRAM word width.
- ADDR_WIDTH, 8, SRAM address width.
- DIM_WIDTH, 5, width of the row/column count fields (tile up to 32x32).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; accepted only in IDLE
- base_addr  input  ADDR_WIDTH  address of tile element (0,0)
- stride  input  ADDR_WIDTH  address increment between rows
- cols_m1  input  DIM_WIDTH  columns minus one
- rows_m1  input  DIM_WIDTH  rows minus one
- busy  output  1  high in RUN or DRAIN
- done  output  1  one-cycle pulse after the last word is popped
- sram_csen  output  1  SRAM chip select
- sram_rd_en  output  1  SRAM read enable
- sram_rd_addr  output  ADDR_WIDTH  SRAM read address
- sram_rd_data  input  DATA_WIDTH  SRAM read data, valid the cycle after sram_rd_en
- out_valid  output  1  stream valid
- out_ready  input  1  stream ready
- out_data  output  DATA_WIDTH  stream data
- out_last_col  output  1  word is the last column of its row
- out_last_row  output  1  word is in the last row; the word with both last flags high ends the frame

Behaviour:
- Reset: all outputs 0, FSM=IDLE, FIFO empty, in-flight flag 0, counters 0. Reset mid-tile aborts the tile immediately, with no done pulse.
- IDLE:
  - On the start edge, latch base_addr, stride, cols_m1, rows_m1; clear col/row counters; set row_base=base_addr, rd_addr=base_addr; go to RUN.
  - Config inputs are ignored at all other times.
- RUN:
  - sram_csen=1.
  - issue = (fifo_count + inflight - pop) < 2, where pop = out_valid & out_ready.
  - sram_rd_en = issue, with sram_rd_addr = current address.
  - On issue: if col<cols_m1, col++ and addr++. Otherwise col=0, row++, row_base += stride, addr = new row_base.
  - Tag bits last_col = (col==cols_m1) and last_row = (row==rows_m1) travel in a 1-deep pipe aligned with the SRAM read latency.
  - Issuing the final element (col==cols_m1 and row==rows_m1) moves the FSM to DRAIN.
- DRAIN:
  - sram_csen=1, sram_rd_en=0.
  - Exit when inflight==0, fifo empty, and no pop is in progress.
  - On exit, done pulses for 1 cycle and the FSM returns to IDLE.
- Latency pipe: inflight is set on each issue edge. On the next edge, {sram_rd_data, last_col, last_row} is pushed into a 2-entry FIFO.
- Credit rule: the credit rule guarantees the FIFO never overflows, so push is unconditional.
- Output: out_valid = fifo not empty; out_data/flags come from the FIFO head, stable while out_valid & !out_ready.
- Timing, out_ready held high: first out_valid rises after the 2nd rising edge following the start edge. Thereafter 1 word/cycle; total tile time is N+3 cycles including the done pulse.
- Address arithmetic is modulo 2^ADDR_WIDTH; wrap past the top is legal and silent.
- A 1x1 tile (cols_m1=0, rows_m1=0) issues one read, emits one word with both flags set, then pulses done.
- A start asserted during RUN/DRAIN, or in the same cycle as done, is ignored.

Decomposition:
- Shared package lenet_pkg:
  - FSM state encoding (IDLE/RUN/DRAIN).
  - FIFO_DEPTH=2.
  - Tag field widths: {data, last_col, last_row}.
- One sub-module: fmap_skid_fifo, a 2-entry register FIFO with push/pop/count/head outputs, parameterised on payload width.
- Address generation and FSM stay in the top.

Test Plan:
- 3x2 tile, base=0x10, stride=4, out_ready=1:
  - rd_addr sequence 0x10,0x11,0x12,0x14,0x15,0x16 on consecutive cycles.
  - out_data matches a preloaded mem[] image.
  - last_col on words 3 and 6; last_row on words 4-6.
  - done exactly once.
- Same tile with out_ready toggling 1,0,0,1 repeating:
  - No word lost or duplicated, output order preserved.
  - sram_rd_en never asserted when fifo_count+inflight-pop would reach 2.
  - out_data stable while stalled.
- 1x1 tile at base=0xFF: single read at 0xFF, one word with both flags high, done 4 cycles after the start edge.
- Wrap: base=0xFE, cols_m1=3, rows_m1=0 -> addresses 0xFE,0xFF,0x00,0x01.
- rst_n deasserted mid-RUN after 2 pops:
  - All outputs 0 immediately, no done pulse.
  - A fresh start after reset release reads the whole tile from base_addr.
- start pulsed during DRAIN and in the done cycle: ignored. busy falls with done; a subsequent start in IDLE is accepted.

Source files
------------

// File: rtl/lenet_pkg.sv
// Shared definitions for the LeNet feature-map datapath: FSM encoding,
// skid FIFO geometry and the stream tag layout.
package lenet_pkg;

  // Reader FSM encoding, kept as plain constants for legacy tooling.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // The skid FIFO only has to cover the one-cycle SRAM read latency.
  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

  // Marker bits carried alongside each data word: {last_col, last_row}.
  localparam int TAG_WIDTH = 2;

  typedef struct packed {
    logic last_col;
    logic last_row;
  } tag_t;

endpackage

// File: rtl/fmap_skid_fifo.sv
// Small register FIFO that absorbs words arriving from the SRAM while the
// downstream stage is stalled. The caller guarantees it is never pushed
// when full and never popped when empty.
module fmap_skid_fifo
  import lenet_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic [WIDTH-1:0]      i_data,
  input  logic                  i_pop,
  output logic [FIFO_CNT_W-1:0] o_count,
  output logic [WIDTH-1:0]      o_head
);

  logic [WIDTH-1:0]      r_mem [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] r_wr_ptr;
  logic [FIFO_PTR_W-1:0] r_rd_ptr;
  logic [FIFO_CNT_W-1:0] r_count;

  // Storage, pointers and occupancy.
  // NOTE: the storage is reset too, because o_head drives module outputs
  // that must read as zero while reset is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + FIFO_PTR_W'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + FIFO_PTR_W'(1);
      end
      r_count <= r_count + FIFO_CNT_W'(i_push) - FIFO_CNT_W'(i_pop);
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/fmap_sram_reader.sv
// Raster-scan tile reader for the feature-map SRAM. Walks a rectangular
// tile row by row, hides the one-cycle SRAM read latency behind a credit
// scheme and a 2-entry skid FIFO, and streams words with row/frame markers.
module fmap_sram_reader
  import lenet_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int DIM_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] stride,
  input  logic [DIM_WIDTH-1:0]  cols_m1,
  input  logic [DIM_WIDTH-1:0]  rows_m1,
  output logic                  busy,
  output logic                  done,
  output logic                  sram_csen,
  output logic                  sram_rd_en,
  output logic [ADDR_WIDTH-1:0] sram_rd_addr,
  input  logic [DATA_WIDTH-1:0] sram_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last_col,
  output logic                  out_last_row
);

  localparam int PAYLOAD_W = DATA_WIDTH + TAG_WIDTH;
  localparam int CREDIT_W  = FIFO_CNT_W + 1;

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_stride;
  logic [ADDR_WIDTH-1:0] r_row_base;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DIM_WIDTH-1:0]  r_cols_m1;
  logic [DIM_WIDTH-1:0]  r_rows_m1;
  logic [DIM_WIDTH-1:0]  r_col;
  logic [DIM_WIDTH-1:0]  r_row;
  logic                  r_inflight;
  tag_t                  r_tag;

  logic                  w_pop;
  logic                  w_issue;
  logic                  w_last_col;
  logic                  w_last_row;
  logic                  w_drain_done;
  logic [CREDIT_W-1:0]   w_credit;
  logic [FIFO_CNT_W-1:0] w_fifo_count;
  logic [PAYLOAD_W-1:0]  w_fifo_head;
  logic [ADDR_WIDTH-1:0] w_next_row_base;

  // Credit check: words already owned (buffered + in flight, minus the one
  // leaving this cycle) must leave room for one more before a read issues.
  // NOTE: every signal gets a default at the top of the block so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_pop           = 1'b0;
    w_credit        = '0;
    w_issue         = 1'b0;
    w_last_col      = 1'b0;
    w_last_row      = 1'b0;
    w_drain_done    = 1'b0;
    w_next_row_base = r_row_base + r_stride;

    w_pop        = out_valid & out_ready;
    w_credit     = CREDIT_W'(w_fifo_count) + CREDIT_W'(r_inflight) - CREDIT_W'(w_pop);
    w_issue      = (r_state == ST_RUN) && (w_credit < CREDIT_W'(FIFO_DEPTH));
    w_last_col   = (r_col == r_cols_m1);
    w_last_row   = (r_row == r_rows_m1);
    // An empty FIFO implies out_valid is low, so no pop can be in progress.
    w_drain_done = (r_state == ST_DRAIN) && !r_inflight && (w_fifo_count == '0);
  end

  // Tile FSM and raster address generation.
  // NOTE: all state updates use non-blocking assignments so every register
  // sees the pre-edge values of the others, whatever the statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_stride   <= '0;
      r_row_base <= '0;
      r_addr     <= '0;
      r_cols_m1  <= '0;
      r_rows_m1  <= '0;
      r_col      <= '0;
      r_row      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_stride   <= stride;
            r_cols_m1  <= cols_m1;
            r_rows_m1  <= rows_m1;
            r_col      <= '0;
            r_row      <= '0;
            r_row_base <= base_addr;
            r_addr     <= base_addr;
            r_state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_issue) begin
            if (!w_last_col) begin
              r_col  <= r_col + DIM_WIDTH'(1);
              r_addr <= r_addr + ADDR_WIDTH'(1);
            end else begin
              r_col      <= '0;
              r_row      <= r_row + DIM_WIDTH'(1);
              r_row_base <= w_next_row_base;
              r_addr     <= w_next_row_base;
            end
            if (w_last_col && w_last_row) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (w_drain_done) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Read-latency pipe: marks a read in flight and carries its tag bits so
  // they line up with the data the SRAM returns one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= 1'b0;
      r_tag      <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_tag <= '{last_col: w_last_col, last_row: w_last_row};
      end
    end
  end

  fmap_skid_fifo #(
    .WIDTH (PAYLOAD_W)
  ) u_skid_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_inflight),
    .i_data  ({sram_rd_data, r_tag}),
    .i_pop   (w_pop),
    .o_count (w_fifo_count),
    .o_head  (w_fifo_head)
  );

  assign busy         = (r_state != ST_IDLE);
  assign done         = w_drain_done;
  assign sram_csen    = busy;
  assign sram_rd_en   = w_issue;
  assign sram_rd_addr = r_addr;
  assign out_valid    = (w_fifo_count != '0);
  assign {out_data, out_last_col, out_last_row} = w_fifo_head;

endmodule
